y86_trace_buffer: RTL
=====================

# y86_trace_buffer

Retirement trace buffer for the SEQ Y86-64 processor.
- Sits directly downstream of the processor top and consumes its per-cycle architectural outputs.
- Captures one record per retired instruction into a FIFO, keeps instruction and cycle counts, and latches the terminating status.
- The testbench or a debug port drains records through a valid/ready interface, and a `done` flag marks the end of the run.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 32: width of `instr_count`, `cycle_count` and `drop_count`.

- `clk` in 1: processor clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `icode` in 4, `ifun` in 4, `rA` in 4, `rB` in 4: fields of the instruction retiring this cycle.
- `PC` in 64: address of the retiring instruction.
- `valE` in 64, `valM` in 64: execute and memory results of the retiring instruction.
- `Status` in 2: processor status; 00 AOK, 01 HLT, 10 ADR, 11 INS.
- `out_rec` out 210: oldest record, packed as {Status, icode, ifun, rA, rB, PC, valE, valM}, MSB first.
- `out_valid` out 1: `out_rec` is valid.
- `out_ready` in 1: consumer accepts `out_rec`.
- `instr_count` out CNT_W: instructions retired.
- `cycle_count` out CNT_W: cycles since reset.
- `drop_count` out CNT_W: records lost to a full FIFO.
- `overflow` out 1: sticky; set on the first drop.
- `final_status` out 2: status latched at termination.
- `done` out 1: run terminated and FIFO drained.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset enters RUN.
- **RUN, every cycle**
  - A record is formed from the inputs and pushed.
  - `instr_count` increments.
  - If `Status != 00`: that record is still pushed, `final_status` ← `Status`, next state is DRAIN.
- **DRAIN**
  - No pushes. Inputs are ignored.
  - Transitions to DONE on the cycle the FIFO becomes empty.
  - If the FIFO is already empty on entry, DRAIN lasts exactly one cycle.
- **DONE**
  - Terminal state; only `reset` leaves it.
  - `done` = 1 and no pushes occur.
- **Pop rule**: a pop occurs when `out_valid && out_ready`. Pops are allowed in every state.
- **Full FIFO, push without pop in the same cycle**
  - The record is discarded.
  - `drop_count` increments and `overflow` sets.
  - `instr_count` still increments.
- **Full FIFO, push with pop in the same cycle**: both are accepted and there is no drop.
- **Empty FIFO with push**: no bypass; `out_valid` rises the next cycle.
- **Counters**
  - `cycle_count` increments every non-reset cycle in all states.
  - All counters wrap modulo 2^CNT_W, except `drop_count`, which saturates at all-ones.
- **Reset values**
  - FIFO is empty, `out_valid` = 0.
  - All counters are 0.
  - `overflow` = 0, `final_status` = 00, `done` = 0.
  - `out_rec` = 0.
- **Reset mid-operation**: unread records are discarded and the block returns to RUN with all outputs at reset values.

## Timing
- Inputs are sampled on the rising edge of `clk`. Inputs are held stable for the whole processor cycle.
- Push-to-`out_valid` latency is 1 cycle. `out_rec` is driven from a register or FIFO RAM read with no combinational path from the inputs.
- `out_ready` → pointer update takes effect at the same edge. `out_valid` does not depend combinationally on `out_ready`.
- `done` asserts on the edge where the FSM enters DONE, which is at least one cycle after the terminating record is pushed.

## Configuration
- Macro: `TRACE_SKIP_NOP_EN`.
- **Defined**: a record with `icode == 4'h1` (nop) is not pushed in RUN.
  - `instr_count` still increments.
  - A nop is never counted as dropped.
- **Undefined**: every retired instruction, including nop, is pushed.
- A record with `Status != 00` is always pushed regardless of the macro.

## Structure
- **Package `y86_trace_pkg`**
  - Status constants: `STAT_AOK`, `STAT_HLT`, `STAT_ADR`, `STAT_INS`.
  - `ICODE_NOP = 4'h1`, `ICODE_HALT = 4'h0`.
  - `TRACE_REC_W = 210`, plus field offset constants.
  - FSM state encoding.
- **Sub-module `trace_fifo`**: parameterised synchronous FIFO with push/pop, full/empty flags and simultaneous push+pop when full.
  - `y86_trace_buffer` adds the FSM, counters and the drop logic on top of it.

## Test plan
- **Streaming**: reset, then 5 AOK cycles with `PC` = 0x0, 0xA, 0x14, 0x1E, 0x28 and `out_ready` = 1 → 5 records out in order, each exactly 1 cycle after its input; `instr_count` = 5; `drop_count` = 0.
- **Halt**: AOK×3, then `Status` = 01 with `icode` = 0 and `out_ready` = 0 → `final_status` = 01. FSM enters DRAIN with 4 records held. Raising `out_ready` drains them, the last with `Status` = 01, and `done` = 1 one cycle after the FIFO empties.
- **Overflow**: `DEPTH` = 16, `out_ready` = 0, 20 AOK cycles → 16 records kept (the first 16 PCs), `drop_count` = 4, `overflow` = 1, `instr_count` = 20.
- **Full with simultaneous push+pop**: FIFO full and `out_ready` = 1 for 3 cycles while pushing → no drops and occupancy stays 16.
- **Nop filtering**: stream nop, irmovq, nop, then `Status` = 11.
  - With `TRACE_SKIP_NOP_EN`: 2 records out, `instr_count` = 4.
  - Without it: 4 records out.
  - In both builds `final_status` = 11.
- **Reset mid-run**: 6 records queued, `reset` held 1 cycle → `out_valid` = 0, all counters 0, FSM back in RUN, and the next push appears on `out_rec` 1 cycle later.

Source files
------------

// File: rtl/y86_trace_pkg.sv
// rtl/y86_trace_pkg.sv - shared constants, record layout and FSM encoding for the Y86 trace buffer
package y86_trace_pkg;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_NOP  = 4'h1;

    localparam int TRACE_REC_W = 210;

    // Field LSB offsets within a record, valM occupies the bottom 64 bits.
    localparam int REC_VALM_LSB   = 0;
    localparam int REC_VALE_LSB   = 64;
    localparam int REC_PC_LSB     = 128;
    localparam int REC_RB_LSB     = 192;
    localparam int REC_RA_LSB     = 196;
    localparam int REC_IFUN_LSB   = 200;
    localparam int REC_ICODE_LSB  = 204;
    localparam int REC_STATUS_LSB = 208;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } trace_state_t;

    function automatic logic [TRACE_REC_W-1:0] pack_rec(
        input logic [1:0]  status,
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] pc,
        input logic [63:0] val_e,
        input logic [63:0] val_m
    );
        return {status, icode, ifun, ra, rb, pc, val_e, val_m};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with push and pop both accepted when full
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 210
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Read data is forced to zero while empty so stale RAM never shows after reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/y86_trace_buffer.sv
// rtl/y86_trace_buffer.sv - retirement trace buffer for SEQ Y86-64; TRACE_SKIP_NOP_EN filters nop records
module y86_trace_buffer
    import y86_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             icode,
    input  logic [3:0]             ifun,
    input  logic [3:0]             rA,
    input  logic [3:0]             rB,
    input  logic [63:0]            PC,
    input  logic [63:0]            valE,
    input  logic [63:0]            valM,
    input  logic [1:0]             Status,
    output logic [TRACE_REC_W-1:0] out_rec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       instr_count,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow,
    output logic [1:0]             final_status,
    output logic                   done
);

    trace_state_t state;
    trace_state_t state_next;

    logic fifo_full;
    logic fifo_empty;
    logic stat_term;
    logic push_req;
    logic pop;
    logic drop;

    assign stat_term = (Status != STAT_AOK);
    assign pop       = out_valid && out_ready;

`ifdef TRACE_SKIP_NOP_EN
    assign push_req = (state == ST_RUN) && ((icode != ICODE_NOP) || stat_term);
`else
    assign push_req = (state == ST_RUN);
`endif

    // A same-cycle pop frees the slot, so only an unpaired push into a full FIFO is lost.
    assign drop = push_req && fifo_full && !pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req && !drop),
        .wdata (pack_rec(Status, icode, ifun, rA, rB, PC, valE, valM)),
        .pop   (pop),
        .rdata (out_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign done      = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (stat_term)  state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count  <= '0;
            cycle_count  <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
            final_status <= STAT_AOK;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (state == ST_RUN) begin
                instr_count <= instr_count + CNT_W'(1);
                if (stat_term) begin
                    final_status <= Status;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
